// File: rtl/axi_wr_if.sv
// AXI write-path bundle (AW, W, B) shared by the arbiter's requester and master sides.
// "master" drives requests and data; "slave" accepts them and returns the response.
interface axi_wr_if #(
  parameter int AW = 32,
  parameter int DW = 64,
  parameter int SW = 8
);
  logic [AW-1:0] awaddr;
  logic [7:0]    awlen;
  logic [2:0]    awsize;
  logic [1:0]    awburst;
  logic          awvalid;
  logic          awready;
  logic [DW-1:0] wdata;
  logic [SW-1:0] wstrb;
  logic          wlast;
  logic          wvalid;
  logic          wready;
  logic [1:0]    bresp;
  logic          bvalid;
  logic          bready;

  modport master (
    output awaddr, awlen, awsize, awburst, awvalid,
    input  awready,
    output wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bresp, bvalid,
    output bready
  );

  modport slave (
    input  awaddr, awlen, awsize, awburst, awvalid,
    output awready,
    input  wdata, wstrb, wlast, wvalid,
    output wready,
    output bresp, bvalid,
    input  bready
  );
endinterface

// File: rtl/axi_wr_arbiter.sv
// Round-robin arbiter sharing one AXI write master between two requesters.
// One whole transaction (AW, all W beats, B) is owned at a time; wlast is regenerated from awlen.
module axi_wr_arbiter (
  input  logic        axi_aclk,
  input  logic        rst,
  axi_wr_if.slave     s0,
  axi_wr_if.slave     s1,
  axi_wr_if.master    m,
  output logic [1:0]  grant,
  output logic        wlast_err
);

  typedef enum logic [1:0] {IDLE, ADDR, DATA, RESP} state_e;

  state_e     state_q;
  logic       gnt_q;
  logic       last_gnt_q;
  logic [7:0] beat_cnt_q;
  logic       wlast_err_q;
  logic [1:0] grant_q;
  logic       gnt_d;

  logic       own_awvalid;
  logic [7:0] own_awlen;
  logic       own_wvalid;
  logic       own_wlast;
  logic       own_bready;
  logic       last_beat;

  // On contention the requester that did not own the previous transaction wins
  assign gnt_d = (s0.awvalid && s1.awvalid) ? ~last_gnt_q : s1.awvalid;

  assign own_awvalid = gnt_q ? s1.awvalid : s0.awvalid;
  assign own_awlen   = gnt_q ? s1.awlen   : s0.awlen;
  assign own_wvalid  = gnt_q ? s1.wvalid  : s0.wvalid;
  assign own_wlast   = gnt_q ? s1.wlast   : s0.wlast;
  assign own_bready  = gnt_q ? s1.bready  : s0.bready;
  assign last_beat   = (beat_cnt_q == 8'd0);

  assign grant     = grant_q;
  assign wlast_err = wlast_err_q;

  always_ff @(posedge axi_aclk) begin
    if (rst) begin
      state_q     <= IDLE;
      gnt_q       <= 1'b0;
      last_gnt_q  <= 1'b1;
      beat_cnt_q  <= 8'd0;
      wlast_err_q <= 1'b0;
      grant_q     <= 2'b00;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (s0.awvalid || s1.awvalid) begin
            gnt_q   <= gnt_d;
            grant_q <= gnt_d ? 2'b10 : 2'b01;
            state_q <= ADDR;
          end
        end
        ADDR: begin
          if (own_awvalid && m.awready) begin
            beat_cnt_q <= own_awlen;
            state_q    <= DATA;
          end
        end
        DATA: begin
          if (own_wvalid && m.wready) begin
            if (own_wlast != last_beat) wlast_err_q <= 1'b1;
            // Counter parks at zero on the final beat, so awlen=255 never wraps
            if (last_beat) state_q <= RESP;
            else           beat_cnt_q <= beat_cnt_q - 8'd1;
          end
        end
        RESP: begin
          if (m.bvalid && own_bready) begin
            last_gnt_q <= gnt_q;
            grant_q    <= 2'b00;
            state_q    <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_comb begin
    m.awaddr   = '0;
    m.awlen    = '0;
    m.awsize   = '0;
    m.awburst  = '0;
    m.awvalid  = 1'b0;
    m.wdata    = '0;
    m.wstrb    = '0;
    m.wlast    = 1'b0;
    m.wvalid   = 1'b0;
    m.bready   = 1'b0;
    s0.awready = 1'b0;
    s0.wready  = 1'b0;
    s0.bvalid  = 1'b0;
    s0.bresp   = 2'b00;
    s1.awready = 1'b0;
    s1.wready  = 1'b0;
    s1.bvalid  = 1'b0;
    s1.bresp   = 2'b00;
    unique case (state_q)
      ADDR: begin
        m.awaddr  = gnt_q ? s1.awaddr  : s0.awaddr;
        m.awlen   = own_awlen;
        m.awsize  = gnt_q ? s1.awsize  : s0.awsize;
        m.awburst = gnt_q ? s1.awburst : s0.awburst;
        m.awvalid = own_awvalid;
        if (gnt_q) s1.awready = m.awready;
        else       s0.awready = m.awready;
      end
      DATA: begin
        m.wdata  = gnt_q ? s1.wdata : s0.wdata;
        m.wstrb  = gnt_q ? s1.wstrb : s0.wstrb;
        m.wlast  = last_beat;
        m.wvalid = own_wvalid;
        if (gnt_q) s1.wready = m.wready;
        else       s0.wready = m.wready;
      end
      RESP: begin
        m.bready = own_bready;
        if (gnt_q) begin
          s1.bvalid = m.bvalid;
          s1.bresp  = m.bresp;
        end else begin
          s0.bvalid = m.bvalid;
          s0.bresp  = m.bresp;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_axi_wr_arbiter.sv
// Directed bench for axi_wr_arbiter: arbitration order, burst beat/wlast generation,
// back-pressure, sticky wlast error, mid-burst reset and B-channel stall.
module tb_axi_wr_arbiter;
  logic       axi_aclk = 1'b0;
  logic       rst;
  logic [1:0] grant;
  logic       wlast_err;
  int         checks = 0;
  int         errors = 0;

  axi_wr_if #(.AW(32), .DW(64), .SW(8)) s0_if ();
  axi_wr_if #(.AW(32), .DW(64), .SW(8)) s1_if ();
  axi_wr_if #(.AW(32), .DW(64), .SW(8)) m_if ();

  axi_wr_arbiter dut (
    .axi_aclk  (axi_aclk),
    .rst       (rst),
    .s0        (s0_if),
    .s1        (s1_if),
    .m         (m_if),
    .grant     (grant),
    .wlast_err (wlast_err)
  );

  always #5 axi_aclk = ~axi_aclk;

  task automatic tick();
    @(posedge axi_aclk);
    #1;
  endtask

  task automatic clear_inputs();
    s0_if.awaddr = '0; s0_if.awlen = '0; s0_if.awsize = '0; s0_if.awburst = '0; s0_if.awvalid = 0;
    s0_if.wdata = '0; s0_if.wstrb = '0; s0_if.wlast = 0; s0_if.wvalid = 0; s0_if.bready = 0;
    s1_if.awaddr = '0; s1_if.awlen = '0; s1_if.awsize = '0; s1_if.awburst = '0; s1_if.awvalid = 0;
    s1_if.wdata = '0; s1_if.wstrb = '0; s1_if.wlast = 0; s1_if.wvalid = 0; s1_if.bready = 0;
    m_if.awready = 0; m_if.wready = 0; m_if.bresp = 2'b00; m_if.bvalid = 0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 1'b1;
    s0_if.awvalid = 1; s1_if.awvalid = 1; s0_if.wvalid = 1;
    m_if.awready = 1; m_if.wready = 1; m_if.bvalid = 1;
    tick(); tick(); #1;
    checks++; if (grant !== 2'b00) begin errors++; $display("FAIL reset_grant: got %b expected 00", grant); end
    checks++; if (m_if.awvalid !== 1'b0) begin errors++; $display("FAIL reset_awvalid: got %b expected 0", m_if.awvalid); end
    checks++; if (m_if.wvalid !== 1'b0) begin errors++; $display("FAIL reset_wvalid: got %b expected 0", m_if.wvalid); end
    checks++; if (s0_if.awready !== 1'b0) begin errors++; $display("FAIL reset_s0_awready: got %b expected 0", s0_if.awready); end
    checks++; if (m_if.bready !== 1'b0) begin errors++; $display("FAIL reset_bready: got %b expected 0", m_if.bready); end
    checks++; if (wlast_err !== 1'b0) begin errors++; $display("FAIL reset_wlast_err: got %b expected 0", wlast_err); end
    rst = 1'b0;
    tick(); #1;
    checks++; if (grant !== 2'b01) begin errors++; $display("FAIL reset_first_winner: got %b expected 01", grant); end
  endtask

  task automatic test_single_s0();
    logic leak;
    logic exp_last;
    logic [63:0] exp_data;
    leak = 1'b0;
    do_reset();
    m_if.awready = 1; m_if.wready = 1; m_if.bvalid = 1; m_if.bresp = 2'b01;
    s0_if.awaddr = 32'h1000_0040; s0_if.awlen = 8'd3; s0_if.awsize = 3'd3; s0_if.awburst = 2'b01;
    s0_if.awvalid = 1; s0_if.bready = 1;
    #1;
    checks++; if (grant !== 2'b00) begin errors++; $display("FAIL single_arb_latency: got %b expected 00", grant); end
    tick(); #1;
    checks++; if (grant !== 2'b01) begin errors++; $display("FAIL single_grant: got %b expected 01", grant); end
    checks++; if (m_if.awvalid !== 1'b1) begin errors++; $display("FAIL single_awvalid: got %b expected 1", m_if.awvalid); end
    checks++; if (m_if.awaddr !== 32'h1000_0040) begin errors++; $display("FAIL single_awaddr: got %h expected 10000040", m_if.awaddr); end
    checks++; if (m_if.awlen !== 8'd3) begin errors++; $display("FAIL single_awlen: got %0d expected 3", m_if.awlen); end
    checks++; if (s0_if.awready !== 1'b1) begin errors++; $display("FAIL single_awready: got %b expected 1", s0_if.awready); end
    leak |= s1_if.awready | s1_if.wready | s1_if.bvalid | (|s1_if.bresp);
    tick();
    s0_if.awvalid = 0; s0_if.wvalid = 1; s0_if.wstrb = 8'hFF;
    for (int b = 0; b < 4; b++) begin
      exp_data = 64'hA000_0000_0000_0000 + 64'(b);
      exp_last = (b == 3);
      s0_if.wdata = exp_data;
      s0_if.wlast = exp_last;
      #1;
      checks++; if (m_if.wdata !== exp_data) begin errors++; $display("FAIL single_wdata[%0d]: got %h expected %h", b, m_if.wdata, exp_data); end
      checks++; if (m_if.wlast !== exp_last) begin errors++; $display("FAIL single_wlast[%0d]: got %b expected %b", b, m_if.wlast, exp_last); end
      checks++; if (s0_if.wready !== 1'b1) begin errors++; $display("FAIL single_wready[%0d]: got %b expected 1", b, s0_if.wready); end
      leak |= s1_if.awready | s1_if.wready | s1_if.bvalid | (|s1_if.bresp);
      tick();
    end
    s0_if.wvalid = 0;
    #1;
    checks++; if (s0_if.bvalid !== 1'b1) begin errors++; $display("FAIL single_bvalid: got %b expected 1", s0_if.bvalid); end
    checks++; if (s0_if.bresp !== 2'b01) begin errors++; $display("FAIL single_bresp: got %b expected 01", s0_if.bresp); end
    checks++; if (m_if.bready !== 1'b1) begin errors++; $display("FAIL single_bready: got %b expected 1", m_if.bready); end
    leak |= s1_if.awready | s1_if.wready | s1_if.bvalid | (|s1_if.bresp);
    tick(); #1;
    checks++; if (grant !== 2'b00) begin errors++; $display("FAIL single_idle_grant: got %b expected 00", grant); end
    checks++; if (s0_if.bvalid !== 1'b0) begin errors++; $display("FAIL single_idle_bvalid: got %b expected 0", s0_if.bvalid); end
    checks++; if (m_if.bready !== 1'b0) begin errors++; $display("FAIL single_idle_bready: got %b expected 0", m_if.bready); end
    leak |= s1_if.awready | s1_if.wready | s1_if.bvalid | (|s1_if.bresp);
    checks++; if (leak !== 1'b0) begin errors++; $display("FAIL single_s1_quiet: got %b expected 0", leak); end
  endtask

  task automatic test_back_to_back();
    logic [1:0]  exp_g;
    logic [63:0] exp_data;
    do_reset();
    m_if.awready = 1; m_if.wready = 1; m_if.bvalid = 1;
    s0_if.awvalid = 1; s0_if.wvalid = 1; s0_if.wlast = 1; s0_if.bready = 1; s0_if.wdata = 64'h5555;
    s1_if.awvalid = 1; s1_if.wvalid = 1; s1_if.wlast = 1; s1_if.bready = 1; s1_if.wdata = 64'h6666;
    for (int k = 0; k < 4; k++) begin
      exp_g    = (k % 2 == 0) ? 2'b01 : 2'b10;
      exp_data = (k % 2 == 0) ? 64'h5555 : 64'h6666;
      tick(); #1;
      checks++; if (grant !== exp_g) begin errors++; $display("FAIL rr_grant[%0d]: got %b expected %b", k, grant, exp_g); end
      checks++; if ((s0_if.wready | s1_if.wready) !== 1'b0) begin errors++; $display("FAIL rr_no_early_w[%0d]: got 1 expected 0", k); end
      tick(); #1;
      checks++; if (m_if.wdata !== exp_data) begin errors++; $display("FAIL rr_wdata[%0d]: got %h expected %h", k, m_if.wdata, exp_data); end
      checks++; if (m_if.wlast !== 1'b1) begin errors++; $display("FAIL rr_wlast[%0d]: got %b expected 1", k, m_if.wlast); end
      tick(); tick(); #1;
      checks++; if (grant !== 2'b00) begin errors++; $display("FAIL rr_idle_gap[%0d]: got %b expected 00", k, grant); end
    end
    checks++; if (wlast_err !== 1'b0) begin errors++; $display("FAIL rr_wlast_err: got %b expected 0", wlast_err); end
  endtask

  task automatic test_wready_toggle();
    int          beats;
    logic [63:0] exp_data;
    logic        exp_last;
    logic        exp_rdy;
    beats = 0;
    do_reset();
    m_if.awready = 1; m_if.wready = 0;
    s1_if.awaddr = 32'h2000_0000; s1_if.awlen = 8'd1; s1_if.awvalid = 1;
    tick(); #1;
    checks++; if (grant !== 2'b10) begin errors++; $display("FAIL toggle_grant: got %b expected 10", grant); end
    tick();
    s1_if.awvalid = 0; s1_if.wvalid = 1; s1_if.wdata = 64'hD0; s1_if.wlast = 0;
    for (int c = 0; c < 4; c++) begin
      exp_rdy = (c % 2 == 1);
      m_if.wready = exp_rdy;
      if (c == 2) begin s1_if.wdata = 64'hD1; s1_if.wlast = 1; end
      exp_data = (c < 2) ? 64'hD0 : 64'hD1;
      exp_last = (c >= 2);
      #1;
      checks++; if (m_if.wdata !== exp_data) begin errors++; $display("FAIL toggle_wdata[%0d]: got %h expected %h", c, m_if.wdata, exp_data); end
      checks++; if (m_if.wlast !== exp_last) begin errors++; $display("FAIL toggle_wlast[%0d]: got %b expected %b", c, m_if.wlast, exp_last); end
      checks++; if (s1_if.wready !== exp_rdy) begin errors++; $display("FAIL toggle_wready[%0d]: got %b expected %b", c, s1_if.wready, exp_rdy); end
      if (m_if.wvalid && m_if.wready) beats++;
      tick();
    end
    #1;
    checks++; if (m_if.wvalid !== 1'b0) begin errors++; $display("FAIL toggle_extra_beat: got %b expected 0", m_if.wvalid); end
    checks++; if (beats != 2) begin errors++; $display("FAIL toggle_beats: got %0d expected 2", beats); end
    s1_if.wvalid = 0; m_if.bvalid = 1; s1_if.bready = 1;
    #1;
    checks++; if (s1_if.bvalid !== 1'b1) begin errors++; $display("FAIL toggle_s1_bvalid: got %b expected 1", s1_if.bvalid); end
    checks++; if (s0_if.bvalid !== 1'b0) begin errors++; $display("FAIL toggle_s0_bvalid: got %b expected 0", s0_if.bvalid); end
    tick();
  endtask

  task automatic test_wlast_err();
    do_reset();
    m_if.awready = 1; m_if.wready = 1; m_if.bvalid = 1;
    s0_if.awvalid = 1; s0_if.awlen = 8'd2; s0_if.bready = 1;
    tick(); tick();
    s0_if.awvalid = 0; s0_if.wvalid = 1;
    for (int b = 0; b < 3; b++) begin
      s0_if.wlast = (b == 1);
      s0_if.wdata = 64'(b);
      #1;
      if (b == 1) begin
        checks++; if (wlast_err !== 1'b0) begin errors++; $display("FAIL werr_before: got %b expected 0", wlast_err); end
      end
      if (b == 2) begin
        checks++; if (wlast_err !== 1'b1) begin errors++; $display("FAIL werr_set: got %b expected 1", wlast_err); end
      end
      tick();
    end
    s0_if.wvalid = 0;
    tick(); #1;
    checks++; if (wlast_err !== 1'b1) begin errors++; $display("FAIL werr_hold_idle: got %b expected 1", wlast_err); end
    s0_if.awvalid = 1; s0_if.awlen = 8'd0;
    tick(); tick();
    s0_if.awvalid = 0; s0_if.wvalid = 1; s0_if.wlast = 1;
    tick();
    s0_if.wvalid = 0;
    tick(); #1;
    checks++; if (grant !== 2'b00) begin errors++; $display("FAIL werr_clean_done: got %b expected 00", grant); end
    checks++; if (wlast_err !== 1'b1) begin errors++; $display("FAIL werr_sticky: got %b expected 1", wlast_err); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    checks++; if (wlast_err !== 1'b0) begin errors++; $display("FAIL werr_cleared: got %b expected 0", wlast_err); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    m_if.awready = 1; m_if.wready = 1; m_if.bvalid = 1;
    s0_if.bready = 1;
    // Complete one s0 write so round-robin would now favour s1
    s0_if.awvalid = 1; s0_if.awlen = 8'd0;
    tick(); tick();
    s0_if.awvalid = 0; s0_if.wvalid = 1; s0_if.wlast = 1;
    tick();
    s0_if.wvalid = 0;
    tick();
    s0_if.awvalid = 1; s0_if.awlen = 8'd3;
    tick(); tick();
    s0_if.awvalid = 0; s0_if.wvalid = 1; s0_if.wlast = 1;
    tick(); #1;
    checks++; if (wlast_err !== 1'b1) begin errors++; $display("FAIL rmid_err_pre: got %b expected 1", wlast_err); end
    rst = 1'b1;
    s0_if.awvalid = 1; s1_if.awvalid = 1;
    tick(); #1;
    checks++; if (grant !== 2'b00) begin errors++; $display("FAIL rmid_grant: got %b expected 00", grant); end
    checks++; if (m_if.wvalid !== 1'b0) begin errors++; $display("FAIL rmid_wvalid: got %b expected 0", m_if.wvalid); end
    checks++; if (s0_if.wready !== 1'b0) begin errors++; $display("FAIL rmid_wready: got %b expected 0", s0_if.wready); end
    checks++; if (m_if.awvalid !== 1'b0) begin errors++; $display("FAIL rmid_awvalid: got %b expected 0", m_if.awvalid); end
    checks++; if (s0_if.bvalid !== 1'b0) begin errors++; $display("FAIL rmid_bvalid: got %b expected 0", s0_if.bvalid); end
    checks++; if (wlast_err !== 1'b0) begin errors++; $display("FAIL rmid_wlast_err: got %b expected 0", wlast_err); end
    rst = 1'b0;
    tick(); #1;
    checks++; if (grant !== 2'b01) begin errors++; $display("FAIL rmid_regrant: got %b expected 01", grant); end
  endtask

  task automatic test_b_stall();
    do_reset();
    m_if.awready = 1; m_if.wready = 1; m_if.bvalid = 1; m_if.bresp = 2'b10;
    s0_if.awvalid = 1; s0_if.awlen = 8'd0; s0_if.bready = 0;
    s1_if.awvalid = 1; s1_if.awlen = 8'd0;
    tick(); tick();
    s0_if.awvalid = 0; s0_if.wvalid = 1; s0_if.wlast = 1;
    tick();
    s0_if.wvalid = 0;
    for (int i = 0; i < 5; i++) begin
      #1;
      checks++; if (m_if.bready !== 1'b0) begin errors++; $display("FAIL bstall_bready[%0d]: got %b expected 0", i, m_if.bready); end
      checks++; if (grant !== 2'b01) begin errors++; $display("FAIL bstall_grant[%0d]: got %b expected 01", i, grant); end
      checks++; if (s1_if.awready !== 1'b0) begin errors++; $display("FAIL bstall_s1_awready[%0d]: got %b expected 0", i, s1_if.awready); end
      tick();
    end
    s0_if.bready = 1;
    #1;
    checks++; if (m_if.bready !== 1'b1) begin errors++; $display("FAIL bstall_release: got %b expected 1", m_if.bready); end
    checks++; if (s0_if.bresp !== 2'b10) begin errors++; $display("FAIL bstall_bresp: got %b expected 10", s0_if.bresp); end
    tick();
    s0_if.bready = 0;
    #1;
    checks++; if (grant !== 2'b00) begin errors++; $display("FAIL bstall_idle: got %b expected 00", grant); end
    tick(); #1;
    checks++; if (grant !== 2'b10) begin errors++; $display("FAIL bstall_s1_grant: got %b expected 10", grant); end
    checks++; if (s1_if.awready !== 1'b1) begin errors++; $display("FAIL bstall_s1_awready_after: got %b expected 1", s1_if.awready); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, expected finish", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    clear_inputs();
    test_reset();
    test_single_s0();
    test_back_to_back();
    test_wready_toggle();
    test_wlast_err();
    test_reset_mid();
    test_b_stall();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/axi_wr_arbiter.md
Name: axi_wr_arbiter

Overview:
- Two-requester write-path arbiter that shares one AXI write master (AW, W and B channels) between requester ports s0 and s1.
- Grants one complete write transaction at a time: AW accept, all W beats, then the B response. The grant is held for the whole transaction.
- Arbitration is round-robin. The arbiter generates `wlast` itself from the granted `awlen`.
- Sits between the write-path sources and the AXI protocol FSM / slave model.

Parameters:
- AW, 32, address width
- DW, 64, write data width
- SW, 8, strobe width (DW/8)

Ports:
- axi_aclk  input  1  clock
- rst  input  1  synchronous active-high reset
- s0_awaddr, s1_awaddr  input  AW  requester write address
- s0_awlen, s1_awlen  input  8  burst length minus 1
- s0_awsize, s1_awsize  input  3  burst size
- s0_awburst, s1_awburst  input  2  burst type
- s0_awvalid, s1_awvalid  input  1  address request
- s0_awready, s1_awready  output  1  address accepted
- s0_wdata, s1_wdata  input  DW  write data
- s0_wstrb, s1_wstrb  input  SW  byte strobes
- s0_wlast, s1_wlast  input  1  requester's last flag (checked only, not forwarded)
- s0_wvalid, s1_wvalid  input  1  data valid
- s0_wready, s1_wready  output  1  data accepted
- s0_bresp, s1_bresp  output  2  routed response
- s0_bvalid, s1_bvalid  output  1  routed response valid
- s0_bready, s1_bready  input  1  requester response ready
- m_awaddr/m_awlen/m_awsize/m_awburst  output  AW/8/3/2  master address fields
- m_awvalid  output  1  master address valid
- m_awready  input  1  slave address ready
- m_wdata/m_wstrb  output  DW/SW  master data and strobes
- m_wlast  output  1  arbiter-generated last beat
- m_wvalid  output  1  master data valid
- m_wready  input  1  slave data ready
- m_bresp  input  2  slave response code
- m_bvalid  input  1  slave response valid
- m_bready  output  1  master response ready
- grant  output  2  one-hot current owner; 00 when idle
- wlast_err  output  1  sticky requester-wlast mismatch flag

Behaviour:
- State register: IDLE, ADDR, DATA, RESP. Registers: `gnt` (1 bit, owner index), `last_gnt`, `beat_cnt` (8 bit), `wlast_err`.
- Reset (synchronous, any state, mid-burst included):
  - state=IDLE, last_gnt=1 (so s0 wins first), beat_cnt=0, wlast_err=0.
  - All valid and ready outputs are 0; grant=00.
  - An in-flight transaction is abandoned; there is no drain.
- IDLE:
  - One requester awvalid: grant it.
  - Both awvalid: grant the one not equal to last_gnt.
  - Next state is ADDR. Grant is registered, so m_awvalid rises one cycle after the winning awvalid (arbitration latency 1).
  - No awvalid: stay in IDLE; all outputs 0.
- ADDR:
  - m_aw* fields and m_awvalid = granted requester's signals, combinational.
  - Granted s_awready = m_awready. Non-granted awready = 0.
  - On the m_awvalid && m_awready handshake: beat_cnt <= m_awlen, go to DATA.
  - If the granted requester drops awvalid, stay in ADDR (a protocol violation by the requester; no recovery required).
- DATA:
  - m_wdata/m_wstrb/m_wvalid come from the owner. Owner's wready = m_wready. Other requester's wready = 0.
  - m_wlast = (beat_cnt==0).
  - Each W handshake: beat_cnt decrements.
  - On any handshake where the owner's s_wlast != m_wlast, set wlast_err=1; it stays set until reset.
  - Handshake with m_wlast=1: go to RESP.
  - awlen=0 gives a single beat with m_wlast=1; awlen=255 gives 256 beats, counter ending at 0 with no wrap.
- RESP:
  - m_bready = owner's bready.
  - Owner's bvalid = m_bvalid; owner's bresp = m_bresp.
  - Non-owner bvalid = 0 and bresp = 00.
  - On B handshake: last_gnt <= gnt, go to IDLE. A new arbitration round is possible on the next cycle, so the minimum gap between AW handshakes is 1 idle cycle.
- Other routing rules:
  - m_bvalid outside RESP is not forwarded; m_bready=0.
  - The non-owner's requests stay pending and are never dropped.
- Throughput:
  - Single outstanding transaction.
  - No AW/W overlap: W beats are accepted only after the AW handshake.
  - W beats presented early by the owner are held off with wready=0.

Test Plan:
- s0 only, awlen=3, m_awready/m_wready/m_bvalid always 1:
  - grant=01 one cycle after awvalid;
  - 4 W beats with m_wlast on beat 4 only;
  - s0_bvalid=1 for one cycle;
  - returns to IDLE; s1 outputs stay 0 throughout.
- s0 and s1 awvalid in the same cycle, back-to-back awlen=0 writes:
  - grant order s0, s1, s0, s1 (round-robin);
  - one idle cycle between transactions.
- s1 burst awlen=1 with m_wready toggling 0/1 each cycle:
  - exactly 2 beats forwarded; data unchanged while m_wready=0;
  - beat_cnt 1 then 0; m_wlast only with the second beat.
- s0 awlen=2 with s0_wlast asserted on beat 2:
  - wlast_err=1 after that handshake and stays 1 across later clean transactions until rst.
- rst asserted mid-DATA (after 1 of 4 beats):
  - next cycle: grant=00, all valid/ready outputs 0, wlast_err=0, state IDLE;
  - next arbitration grants s0.
- B stall: m_bvalid=1 with s0_bready=0 for 5 cycles:
  - m_bready=0 and grant stays 01;
  - pending s1_awvalid is not granted until the B handshake, then granted one cycle after IDLE.
